// File: rtl/div_hilo_unit_if.sv
// Request/response bundle between the EX-stage control and the HI/LO divider.
// The master drives DIV/MF requests; the slave (div_hilo_unit) returns HI/LO, busy, stall and done.
interface div_hilo_unit_if;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [1:0]  mf;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output div_start, dividend, divisor, mf,
        input  mf_data, hi, lo, busy, stall, done
    );

    modport slave (
        input  div_start, dividend, divisor, mf,
        output mf_data, hi, lo, busy, stall, done
    );
endinterface

// File: rtl/div_hilo_unit.sv
// Multi-cycle signed 32-bit restoring divider with the architectural HI/LO pair and MFHI/MFLO read path.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor| (latency only, same results).
module div_hilo_unit (
    input logic            clk,
    input logic            rst,
    div_hilo_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e      state_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;
    logic        qsign_q;
    logic        rsign_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    assign abs_a = bus.dividend[31] ? (32'd0 - bus.dividend) : bus.dividend;
    assign abs_b = bus.divisor[31]  ? (32'd0 - bus.divisor)  : bus.divisor;

    // A borrow out of the 33-bit trial subtraction means the shifted remainder is below the divisor.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign rem_d   = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_d   = {quo_q[30:0], ~diff[32]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 5'd0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.div_start) begin
                        cnt_q  <= 5'd0;
                        busy_q <= 1'b1;
                        if (bus.divisor == 32'd0) begin
                            rem_q   <= bus.dividend;
                            quo_q   <= 32'hFFFF_FFFF;
                            dvs_q   <= 32'd0;
                            qsign_q <= 1'b0;
                            rsign_q <= 1'b0;
                            state_q <= FIX;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (abs_a < abs_b) begin
                            rem_q   <= abs_a;
                            quo_q   <= 32'd0;
                            dvs_q   <= abs_b;
                            qsign_q <= bus.dividend[31] ^ bus.divisor[31];
                            rsign_q <= bus.dividend[31];
                            state_q <= FIX;
                        end
`endif
                        else begin
                            rem_q   <= 32'd0;
                            quo_q   <= abs_a;
                            dvs_q   <= abs_b;
                            qsign_q <= bus.dividend[31] ^ bus.divisor[31];
                            rsign_q <= bus.dividend[31];
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q    <= qsign_q ? (32'd0 - quo_q) : quo_q;
                    hi_q    <= rsign_q ? (32'd0 - rem_q) : rem_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mf_data = 32'd0;
        if (bus.mf == 2'b10) begin
            bus.mf_data = hi_q;
        end else if (bus.mf == 2'b11) begin
            bus.mf_data = lo_q;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.mf[1] | bus.div_start);
endmodule
